// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: small circular FIFO feeding a start/data/stop serialiser.
// Every bit lasts (baud_div + 1) cycles. The divisor is sampled once per frame, when the frame starts.
//
// state | meaning
// IDLE  | line high, waiting for en and a queued byte
// START | start bit (low) on the line
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); may chain straight into the next START
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int DIV_W = 16
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    input  logic                     en,
    input  logic [DIV_W-1:0]         baud_div,
    input  logic [7:0]               wdata,
    input  logic                     wr,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    output logic                     tx,
    output logic                     busy,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]       mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
    logic             empty, push, pop, load;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign push  = wr & ~full;
    assign level = wptr_q - rptr_q;

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;

    // Storage needs no reset: the pointers alone decide what is valid.
    always_ff @(posedge HCLK) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && !empty) load = 1'b1;
            end
            START: begin
                if (cnt_q == '0) begin
                    state_d = DATA;
                    cnt_d   = div_q;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = div_q;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    done_d = 1'b1;
                    if (en && !empty) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Frame start, shared by IDLE and the back-to-back path out of STOP.
        if (load) begin
            state_d = START;
            shift_d = mem_q[rptr_q[AW-1:0]];
            div_d   = baud_div;
            cnt_d   = baud_div;
            bit_d   = 3'd0;
            tx_d    = 1'b0;
        end
    end

    assign pop    = load;
    assign wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    assign rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
    assign busy_d = (state_d != IDLE);
    assign ovf_d  = wr & full;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame timing and bit order, back-to-back frames, overflow,
// enable gating, minimum divisor and asynchronous reset in the middle of a frame.
module tb_uart_tx_fifo;
    logic        HCLK, HRESET, en, wr;
    logic [15:0] baud_div;
    logic [7:0]  wdata;
    logic        full, ovf, tx, busy, done;
    logic [2:0]  level;

    int checks = 0;
    int errors = 0;

    uart_tx_fifo #(.DEPTH(4), .DIV_W(16)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .en(en), .baud_div(baud_div),
        .wdata(wdata), .wr(wr), .full(full), .level(level), .ovf(ovf),
        .tx(tx), .busy(busy), .done(done)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        wr = 1'b1;
        wdata = b;
        tick();
        wr = 1'b0;
    endtask

    // Entered just after the edge at which tx fell for the start bit.
    // It leaves just after the edge that ends the stop bit, which is the cycle in which done is high.
    task automatic check_frame(input string tag, input logic [7:0] b, input int div,
                               input int drop_at, input int chg_at);
        logic [9:0] fb;
        logic [7:0] rx;
        int nerr, n, bi;
        fb = {1'b1, b, 1'b0};
        rx = 8'h00;
        nerr = 0;
        n = 10 * (div + 1);
        for (int i = 0; i < n; i++) begin
            bi = i / (div + 1);
            if (tx !== fb[bi]) nerr++;
            if ((i % (div + 1)) == div / 2 && bi >= 1 && bi <= 8) rx[bi-1] = tx;
            if (i == drop_at) en = 1'b0;
            if (i == chg_at) baud_div = 16'd3;
            tick();
        end
        chk({tag, " bit errors"}, nerr, 0);
        chk({tag, " byte"}, {24'h0, rx}, {24'h0, b});
        chk({tag, " done"}, {31'h0, done}, 1);
    endtask

    initial begin
        int lows;
        HRESET = 1'b1;
        en = 1'b0;
        wr = 1'b0;
        wdata = 8'h00;
        baud_div = 16'd15;
        repeat (3) tick();
        HRESET = 1'b0;
        tick();
        chk("rst tx", {31'h0, tx}, 1);
        chk("rst busy", {31'h0, busy}, 0);
        chk("rst done", {31'h0, done}, 0);
        chk("rst ovf", {31'h0, ovf}, 0);
        chk("rst full", {31'h0, full}, 0);
        chk("rst level", {29'h0, level}, 0);

        // Single byte 0x55. baud_div changes mid-frame, so the frame must keep its latched divisor.
        en = 1'b1;
        wr_byte(8'h55);
        chk("t1 level after write", {29'h0, level}, 1);
        chk("t1 busy before start", {31'h0, busy}, 0);
        tick();
        chk("t1 tx start", {31'h0, tx}, 0);
        chk("t1 busy", {31'h0, busy}, 1);
        chk("t1 level after pop", {29'h0, level}, 0);
        check_frame("t1 0x55", 8'h55, 15, -1, 40);
        baud_div = 16'd15;
        chk("t1 busy end", {31'h0, busy}, 0);
        chk("t1 tx idle", {31'h0, tx}, 1);
        tick();
        chk("t1 done pulse width", {31'h0, done}, 0);

        // Three queued bytes, sent back to back.
        en = 1'b0;
        wr_byte("H");
        wr_byte("i");
        wr_byte(8'h0A);
        chk("t2 level 3", {29'h0, level}, 3);
        en = 1'b1;
        tick();
        chk("t2 level 2", {29'h0, level}, 2);
        check_frame("t2 H", "H", 15, -1, -1);
        chk("t2 no gap 1", {31'h0, tx}, 0);
        chk("t2 level 1", {29'h0, level}, 1);
        check_frame("t2 i", "i", 15, -1, -1);
        chk("t2 no gap 2", {31'h0, tx}, 0);
        chk("t2 level 0", {29'h0, level}, 0);
        check_frame("t2 nl", 8'h0A, 15, -1, -1);
        chk("t2 busy end", {31'h0, busy}, 0);

        // Overflow: five writes into a 4-entry FIFO while the transmitter is held off.
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            wr_byte(k[7:0]);
            if (k == 2) chk("t3 not full at 3", {31'h0, full}, 0);
            if (k == 3) begin
                chk("t3 full at 4", {31'h0, full}, 1);
                chk("t3 level at 4", {29'h0, level}, 4);
                chk("t3 no ovf at 4", {31'h0, ovf}, 0);
            end
            if (k == 4) begin
                chk("t3 ovf", {31'h0, ovf}, 1);
                chk("t3 level after drop", {29'h0, level}, 4);
            end
        end
        tick();
        chk("t3 ovf one cycle", {31'h0, ovf}, 0);
        en = 1'b1;
        tick();
        chk("t3 full cleared", {31'h0, full}, 0);
        chk("t3 level 3", {29'h0, level}, 3);
        for (int k = 0; k < 4; k++) begin
            check_frame($sformatf("t3 frame %0d", k), k[7:0], 15, -1, -1);
        end
        chk("t3 busy end", {31'h0, busy}, 0);
        chk("t3 level end", {29'h0, level}, 0);

        // Enable gating: drop en in the middle of data bit 3, with a second byte still queued.
        en = 1'b0;
        wr_byte(8'h3C);
        wr_byte(8'hC3);
        chk("t4 level 2", {29'h0, level}, 2);
        en = 1'b1;
        tick();
        check_frame("t4 0x3C", 8'h3C, 15, 72, -1);
        chk("t4 tx high", {31'h0, tx}, 1);
        chk("t4 busy low", {31'h0, busy}, 0);
        chk("t4 level 1", {29'h0, level}, 1);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        chk("t4 held idle", lows, 0);
        en = 1'b1;
        tick();
        chk("t4 resume start", {31'h0, tx}, 0);
        chk("t4 resume level", {29'h0, level}, 0);
        check_frame("t4 0xC3", 8'hC3, 15, -1, -1);

        // Minimum divisor: 0xA5 in 10 cycles.
        baud_div = 16'd0;
        wr_byte(8'hA5);
        tick();
        chk("t5 start", {31'h0, tx}, 0);
        check_frame("t5 0xA5", 8'hA5, 0, -1, -1);
        chk("t5 busy end", {31'h0, busy}, 0);

        // Reset during data bit 5, with one byte still queued behind the frame in flight.
        baud_div = 16'd15;
        en = 1'b0;
        wr_byte(8'h00);
        wr_byte(8'h00);
        en = 1'b1;
        tick();
        repeat (100) tick();
        chk("t6 mid-frame low", {31'h0, tx}, 0);
        #2;
        HRESET = 1'b1;
        #1;
        chk("t6 async tx", {31'h0, tx}, 1);
        chk("t6 async busy", {31'h0, busy}, 0);
        chk("t6 async level", {29'h0, level}, 0);
        tick();
        tick();
        HRESET = 1'b0;
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        chk("t6 nothing sent", lows, 0);
        chk("t6 level", {29'h0, level}, 0);
        chk("t6 busy", {31'h0, busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
